// File: rtl/gene_sched_pkg.sv
// Shared constants, state encoding and address helper for the gene scan scheduler.
package gene_sched_pkg;

  localparam int unsigned ELEMENT_SIZE     = 4;
  localparam int unsigned CODON_MAX_LENGTH = 5;
  localparam int unsigned ELEMENT_COUNT    = 32;
  localparam int unsigned SEGMENT_SIZE     = ELEMENT_COUNT + CODON_MAX_LENGTH - 1;
  localparam int unsigned GENE_MEM_DEPTH   = 256;
  localparam int unsigned PADDED_DEPTH     = GENE_MEM_DEPTH + CODON_MAX_LENGTH - 1;
  localparam int unsigned PROC_UNIT_COUNT  = GENE_MEM_DEPTH / ELEMENT_COUNT;
  localparam int unsigned MAX_COUNT        = 16;
  localparam int unsigned TIMEOUT_CYCLES   = 1024;

  localparam int unsigned COUNT_W = $clog2(MAX_COUNT + 1);
  localparam int unsigned TOTAL_W = $clog2(PROC_UNIT_COUNT * MAX_COUNT + 1);
  localparam int unsigned ADDR_W  = $clog2(PADDED_DEPTH);
  localparam int unsigned SEL_W   = $clog2(PROC_UNIT_COUNT);
  localparam int unsigned IDX_W   = $clog2(SEGMENT_SIZE);
  localparam int unsigned CODON_W = 3;
  localparam int unsigned TMO_W   = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_RUN,
    S_COLLECT,
    S_FINISH
  } sched_state_t;

  function automatic logic [ADDR_W-1:0] seg_addr(input logic [SEL_W-1:0] k,
                                                 input logic [IDX_W-1:0] i);
    return ADDR_W'(k) * ADDR_W'(ELEMENT_COUNT) + ADDR_W'(i);
  endfunction

endpackage

// File: rtl/gene_seg_addr_gen.sv
// Walks (PU, element) pairs one read per cycle and produces the matching
// one-cycle-delayed segment write strobe and coordinates.
module gene_seg_addr_gen
  import gene_sched_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              load_start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              wr_en,
  output logic [SEL_W-1:0]  wr_sel,
  output logic [IDX_W-1:0]  wr_idx,
  output logic              last_rd_c
);

  logic [SEL_W-1:0]  k_q, k_d;
  logic [IDX_W-1:0]  i_q, i_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_en_q, wr_en_d;
  logic [SEL_W-1:0]  wr_sel_q, wr_sel_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;

  always_comb begin
    k_d       = k_q;
    i_d       = i_q;
    rd_en_d   = rd_en_q;
    wr_en_d   = rd_en_q;
    wr_sel_d  = rd_en_q ? k_q : '0;
    wr_idx_d  = rd_en_q ? i_q : '0;
    last_rd_c = rd_en_q && (k_q == SEL_W'(PROC_UNIT_COUNT - 1)) &&
                (i_q == IDX_W'(SEGMENT_SIZE - 1));
    if (load_start) begin
      k_d     = '0;
      i_d     = '0;
      rd_en_d = 1'b1;
    end else if (rd_en_q) begin
      if (last_rd_c) begin
        rd_en_d = 1'b0;
      end else if (i_q == IDX_W'(SEGMENT_SIZE - 1)) begin
        i_d = '0;
        k_d = k_q + SEL_W'(1);
      end else begin
        i_d = i_q + IDX_W'(1);
      end
    end
    addr_d = rd_en_d ? seg_addr(k_d, i_d) : '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      k_q      <= '0;
      i_q      <= '0;
      rd_en_q  <= 1'b0;
      addr_q   <= '0;
      wr_en_q  <= 1'b0;
      wr_sel_q <= '0;
      wr_idx_q <= '0;
    end else begin
      k_q      <= k_d;
      i_q      <= i_d;
      rd_en_q  <= rd_en_d;
      addr_q   <= addr_d;
      wr_en_q  <= wr_en_d;
      wr_sel_q <= wr_sel_d;
      wr_idx_q <= wr_idx_d;
    end
  end

  assign rd_en   = rd_en_q;
  assign rd_addr = addr_q;
  assign wr_en   = wr_en_q;
  assign wr_sel  = wr_sel_q;
  assign wr_idx  = wr_idx_q;

endmodule

// File: rtl/gene_scan_scheduler.sv
// Sequences one gene scan: load PU segments, launch, wait for all PUs, sum counts.
// Optional RUN watchdog enabled by defining GENE_SCHED_TIMEOUT_EN.
module gene_scan_scheduler
  import gene_sched_pkg::*;
(
  input  logic                                CLK,
  input  logic                                RST,
  input  logic                                start,
  input  logic [CODON_W-1:0]                  codon_len,
  output logic                                busy,
  output logic                                done,
  output logic                                err,
  output logic [TOTAL_W-1:0]                  total_count,
  output logic                                mem_rd_en,
  output logic [ADDR_W-1:0]                   mem_addr,
  input  logic [ELEMENT_SIZE-1:0]             mem_rd_data,
  output logic                                pu_wr_en,
  output logic [SEL_W-1:0]                    pu_wr_sel,
  output logic [IDX_W-1:0]                    pu_wr_idx,
  output logic [ELEMENT_SIZE-1:0]             pu_wr_data,
  output logic                                pu_go,
  output logic [CODON_W-1:0]                  pu_codon_len,
  input  logic [PROC_UNIT_COUNT-1:0]          pu_done,
  input  logic [PROC_UNIT_COUNT*COUNT_W-1:0]  pu_count
);

  sched_state_t               state_q, state_d;
  logic [CODON_W-1:0]         codon_len_q, codon_len_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;
  logic [TOTAL_W-1:0]         total_q, total_d;
  logic                       go_q, go_d;
  logic [PROC_UNIT_COUNT-1:0] sticky_q, sticky_d;
  logic [TOTAL_W-1:0]         acc_q, acc_d;
  logic [SEL_W-1:0]           col_idx_q, col_idx_d;
`ifdef GENE_SCHED_TIMEOUT_EN
  logic [TMO_W-1:0]           tmo_q, tmo_d;
`endif

  logic                       load_start_c;
  logic                       last_rd_c;
  logic                       wr_en_w;
  logic [COUNT_W-1:0]         cur_count_c;

  gene_seg_addr_gen u_addr_gen (
    .CLK        (CLK),
    .RST        (RST),
    .load_start (load_start_c),
    .rd_en      (mem_rd_en),
    .rd_addr    (mem_addr),
    .wr_en      (wr_en_w),
    .wr_sel     (pu_wr_sel),
    .wr_idx     (pu_wr_idx),
    .last_rd_c  (last_rd_c)
  );

  // Read data lands the cycle after its strobe, aligned with the delayed write.
  assign pu_wr_en    = wr_en_w;
  assign pu_wr_data  = wr_en_w ? mem_rd_data : '0;
  assign cur_count_c = pu_count[int'(col_idx_q)*COUNT_W +: COUNT_W];

  always_comb begin
    state_d      = state_q;
    codon_len_d  = codon_len_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    total_d      = total_q;
    go_d         = 1'b0;
    sticky_d     = sticky_q;
    acc_d        = acc_q;
    col_idx_d    = col_idx_q;
    load_start_c = 1'b0;
`ifdef GENE_SCHED_TIMEOUT_EN
    tmo_d        = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          codon_len_d = codon_len;
          if ((codon_len == '0) || (codon_len > CODON_W'(CODON_MAX_LENGTH))) begin
            state_d = S_FINISH;
            done_d  = 1'b1;
            err_d   = 1'b1;
            total_d = '0;
          end else begin
            state_d      = S_LOAD;
            busy_d       = 1'b1;
            load_start_c = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (last_rd_c) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        state_d = S_RUN;
        go_d    = 1'b1;
      end
      S_RUN: begin
        // Done bits seen alongside the launch pulse belong to the previous run.
        if (go_q) begin
          sticky_d = '0;
`ifdef GENE_SCHED_TIMEOUT_EN
          tmo_d    = '0;
`endif
        end else begin
          sticky_d = sticky_q | pu_done;
`ifdef GENE_SCHED_TIMEOUT_EN
          tmo_d    = tmo_q + TMO_W'(1);
`endif
          if (&sticky_q) begin
            state_d   = S_COLLECT;
            acc_d     = '0;
            col_idx_d = '0;
          end
`ifdef GENE_SCHED_TIMEOUT_EN
          else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            state_d = S_FINISH;
            done_d  = 1'b1;
            err_d   = 1'b1;
            busy_d  = 1'b0;
            total_d = '0;
          end
`endif
        end
      end
      S_COLLECT: begin
        acc_d     = acc_q + TOTAL_W'(cur_count_c);
        col_idx_d = col_idx_q + SEL_W'(1);
        if (col_idx_q == SEL_W'(PROC_UNIT_COUNT - 1)) begin
          state_d = S_FINISH;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          total_d = acc_d;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      codon_len_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      total_q     <= '0;
      go_q        <= 1'b0;
      sticky_q    <= '0;
      acc_q       <= '0;
      col_idx_q   <= '0;
`ifdef GENE_SCHED_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      codon_len_q <= codon_len_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      total_q     <= total_d;
      go_q        <= go_d;
      sticky_q    <= sticky_d;
      acc_q       <= acc_d;
      col_idx_q   <= col_idx_d;
`ifdef GENE_SCHED_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign total_count  = total_q;
  assign pu_go        = go_q;
  assign pu_codon_len = codon_len_q;

endmodule

// File: tb/tb_gene_scan_scheduler.sv
// Randomized self-checking bench for gene_scan_scheduler with memory and PU-array models.
module tb_gene_scan_scheduler;
  import gene_sched_pkg::*;

  localparam int NPU = int'(PROC_UNIT_COUNT);
  localparam int NRD = int'(PROC_UNIT_COUNT * SEGMENT_SIZE);

  logic                               CLK = 1'b0;
  logic                               RST;
  logic                               start;
  logic [CODON_W-1:0]                 codon_len;
  logic                               busy, done, err;
  logic [TOTAL_W-1:0]                 total_count;
  logic                               mem_rd_en;
  logic [ADDR_W-1:0]                  mem_addr;
  logic [ELEMENT_SIZE-1:0]            mem_rd_data;
  logic                               pu_wr_en;
  logic [SEL_W-1:0]                   pu_wr_sel;
  logic [IDX_W-1:0]                   pu_wr_idx;
  logic [ELEMENT_SIZE-1:0]            pu_wr_data;
  logic                               pu_go;
  logic [CODON_W-1:0]                 pu_codon_len;
  logic [PROC_UNIT_COUNT-1:0]         pu_done;
  logic [PROC_UNIT_COUNT*COUNT_W-1:0] pu_count;

  gene_scan_scheduler dut (
    .CLK(CLK), .RST(RST), .start(start), .codon_len(codon_len),
    .busy(busy), .done(done), .err(err), .total_count(total_count),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .pu_wr_en(pu_wr_en), .pu_wr_sel(pu_wr_sel), .pu_wr_idx(pu_wr_idx),
    .pu_wr_data(pu_wr_data), .pu_go(pu_go), .pu_codon_len(pu_codon_len),
    .pu_done(pu_done), .pu_count(pu_count)
  );

  always #5 CLK = ~CLK;

  // Gene memory: registered read, data one cycle after the strobe.
  logic [ELEMENT_SIZE-1:0] mem_arr [PADDED_DEPTH];
  always @(posedge CLK) if (mem_rd_en) mem_rd_data <= mem_arr[mem_addr];

  int vectors = 0;
  int errors  = 0;
  int cyc = 0;
  int nrd, nwr, ngo, ndone;
  int s_cyc, go_cyc, done_cyc;
  int lat [NPU];
  int cnt [NPU];
  int rd_cyc_q [$];
  int last_addr;
  bit running, level_mode, extra_en;
  logic done_err, done_busy, done_prev_busy, prev_busy;
  logic [TOTAL_W-1:0] done_total;
  logic [CODON_W-1:0] go_codon;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int exp_addr(input int n);
    return (n / int'(SEGMENT_SIZE)) * int'(ELEMENT_COUNT) + (n % int'(SEGMENT_SIZE));
  endfunction

  function automatic logic [63:0] outs_vec();
    return 64'({busy, done, err, total_count, mem_rd_en, mem_addr, pu_wr_en, pu_wr_sel,
                pu_wr_idx, pu_wr_data, pu_go, pu_codon_len});
  endfunction

  task automatic observe();
    int r;
    if (mem_rd_en) begin
      check_val("rd_addr", 64'(mem_addr), 64'(exp_addr(nrd)));
      rd_cyc_q.push_back(cyc);
      last_addr = int'(mem_addr);
      nrd++;
    end
    if (pu_wr_en) begin
      if (rd_cyc_q.size() == 0) check_val("wr_orphan", 64'(1), 64'(0));
      else begin
        r = rd_cyc_q.pop_front();
        check_val("wr_latency", 64'(cyc - r), 64'(1));
      end
      check_val("wr_sel", 64'(pu_wr_sel), 64'(nwr / int'(SEGMENT_SIZE)));
      check_val("wr_idx", 64'(pu_wr_idx), 64'(nwr % int'(SEGMENT_SIZE)));
      check_val("wr_data", 64'(pu_wr_data), 64'(mem_arr[exp_addr(nwr)]));
      nwr++;
    end
    if (pu_go) begin
      go_cyc   = cyc;
      running  = 1'b1;
      go_codon = pu_codon_len;
      ngo++;
    end
    if (done) begin
      ndone++;
      done_cyc       = cyc;
      done_err       = err;
      done_total     = total_count;
      done_busy      = busy;
      done_prev_busy = prev_busy;
    end
    prev_busy = busy;
  endtask

  // PU array model: done as a level or a pulse, plus a stray pulse on the launch cycle.
  task automatic drive();
    for (int k = 0; k < NPU; k++) begin
      if (running && cyc == go_cyc) begin
        if (!level_mode) pu_done[k] = 1'b1;
      end else if (running) begin
        pu_done[k] = level_mode ? (cyc >= go_cyc + lat[k]) : (cyc == go_cyc + lat[k]);
      end
    end
    start = extra_en && ((cyc == s_cyc + 50) || (done === 1'b1));
  endtask

  task automatic step();
    @(negedge CLK);
    cyc++;
    observe();
    drive();
  endtask

  task automatic launch(input logic [CODON_W-1:0] codon);
    nrd = 0; nwr = 0; ngo = 0; ndone = 0; last_addr = 0;
    running = 1'b0;
    rd_cyc_q.delete();
    for (int k = 0; k < NPU; k++) pu_count[k*int'(COUNT_W) +: COUNT_W] = COUNT_W'(cnt[k]);
    codon_len = codon;
    start     = 1'b1;
    s_cyc     = cyc;
    step();
  endtask

  task automatic scan(input logic [CODON_W-1:0] codon, input bit good);
    int maxlat, sum, quiet;
    maxlat = 0; sum = 0; quiet = 0;
    for (int k = 0; k < NPU; k++) begin
      if (lat[k] > maxlat) maxlat = lat[k];
      sum += cnt[k];
    end
    if (!good) sum = 0;
    launch(codon);
    for (int n = 0; n < 3000 && ndone == 0; n++) step();
    check_val("done_seen", 64'(ndone), 64'(1));
    if (good) begin
      check_val("go_cycle", 64'(go_cyc - s_cyc), 64'(290));
      check_val("done_cycle", 64'(done_cyc - go_cyc), 64'(maxlat + 10));
      check_val("go_count", 64'(ngo), 64'(1));
      check_val("read_count", 64'(nrd), 64'(NRD));
      check_val("last_addr", 64'(last_addr), 64'(PADDED_DEPTH - 1));
      check_val("write_count", 64'(nwr), 64'(NRD));
      check_val("pu_codon_len", 64'(go_codon), 64'(codon));
      check_val("busy_before_done", 64'(done_prev_busy), 64'(1));
      check_val("err", 64'(done_err), 64'(0));
    end else begin
      check_val("bad_latency_le3", 64'(done_cyc - s_cyc <= 3), 64'(1));
      check_val("bad_reads", 64'(nrd), 64'(0));
      check_val("err", 64'(done_err), 64'(1));
    end
    check_val("total_count", 64'(done_total), 64'(sum));
    check_val("busy_at_done", 64'(done_busy), 64'(0));
    step();
    check_val("done_width", 64'(done), 64'(0));
    for (int n = 0; n < 30; n++) begin
      step();
      if (busy || mem_rd_en || done || pu_go) quiet++;
    end
    check_val("quiet_after_done", 64'(quiet), 64'(0));
    check_val("total_held", 64'(total_count), 64'(sum));
  endtask

  task automatic randomize_scan(input int lat_max);
    for (int a = 0; a < int'(PADDED_DEPTH); a++) mem_arr[a] = ELEMENT_SIZE'($urandom);
    for (int k = 0; k < NPU; k++) begin
      cnt[k] = int'($urandom_range(0, MAX_COUNT));
      lat[k] = int'($urandom_range(1, lat_max));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; start = 1'b0; codon_len = '0; pu_done = '0; pu_count = '0;
    extra_en = 1'b0; level_mode = 1'b1; running = 1'b0;
    go_cyc = -1; s_cyc = -100; prev_busy = 1'b0;
    for (int a = 0; a < int'(PADDED_DEPTH); a++) mem_arr[a] = ELEMENT_SIZE'(a % 16);
    repeat (3) step();
    check_val("reset_outputs", outs_vec(), 64'(0));
    RST = 1'b0;
    step();
    check_val("idle_outputs", outs_vec(), 64'(0));

    // Address-pattern memory, counts k+1, all PUs done one cycle after launch.
    for (int k = 0; k < NPU; k++) begin cnt[k] = k + 1; lat[k] = 1; end
    level_mode = 1'b1;
    scan(3'd3, 1'b1);

    // Saturated counts, PU3 100 cycles behind the rest, pulsed done.
    randomize_scan(20);
    for (int k = 0; k < NPU; k++) cnt[k] = int'(MAX_COUNT);
    lat[3] = 0;
    for (int k = 0; k < NPU; k++) if (lat[k] > lat[3]) lat[3] = lat[k];
    lat[3] += 100;
    level_mode = 1'b0;
    scan(3'd5, 1'b1);

    // Illegal codon lengths.
    scan(3'd0, 1'b0);
    scan(3'd6, 1'b0);

    // Stray starts during LOAD and on the done cycle.
    randomize_scan(30);
    level_mode = 1'b1;
    extra_en   = 1'b1;
    scan(3'd1, 1'b1);
    extra_en   = 1'b0;

    for (int t = 0; t < 3; t++) begin
      randomize_scan(40);
      level_mode = 1'($urandom_range(0, 1));
      scan(CODON_W'($urandom_range(1, CODON_MAX_LENGTH)), 1'b1);
    end

    // Reset in the middle of LOAD.
    randomize_scan(10);
    launch(3'd4);
    repeat (100) step();
    RST = 1'b1;
    step();
    check_val("midload_reset_outputs", outs_vec(), 64'(0));
    RST = 1'b0;
    for (int n = 0; n < 400; n++) step();
    check_val("midload_no_done", 64'(ndone), 64'(0));
    check_val("midload_idle", 64'(busy), 64'(0));

    // PU5 never finishes.
    randomize_scan(5);
    lat[5] = 1 << 24;
    level_mode = 1'b1;
    launch(3'd2);
    for (int n = 0; n < 400 && ngo == 0; n++) step();
    check_val("stall_go_seen", 64'(ngo), 64'(1));
`ifdef GENE_SCHED_TIMEOUT_EN
    for (int n = 0; n < int'(TIMEOUT_CYCLES) + 100 && ndone == 0; n++) step();
    check_val("timeout_done_seen", 64'(ndone), 64'(1));
    check_val("timeout_done_cycle", 64'(done_cyc - go_cyc), 64'(TIMEOUT_CYCLES + 1));
    check_val("timeout_err", 64'(done_err), 64'(1));
    check_val("timeout_total", 64'(done_total), 64'(0));
`else
    repeat (int'(TIMEOUT_CYCLES) + 100) step();
    check_val("stall_busy_held", 64'(busy), 64'(1));
    check_val("stall_no_done", 64'(ndone), 64'(0));
    RST = 1'b1;
    step();
    RST = 1'b0;
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
